// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle RV32I control FSM; optional RETIRE_COUNTER_EN adds o_RetireCount
module multicycle_sequencer #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Branch,
  input  logic       i_Jump,
  input  logic       i_RegWrite,
  input  logic       i_MemRead,
  input  logic       i_MemWrite,
  input  logic       i_IllegalInstruction,
  input  logic       i_BranchTaken,
  input  logic       i_BusReady,
  output logic       o_BusReq,
  output logic       o_BusWrite,
  output logic       o_BusAddrSel,
  output logic       o_IrWrite,
  output logic       o_OperandLatch,
  output logic       o_AluLatch,
  output logic       o_MemDataLatch,
  output logic       o_RegFileWrite,
  output logic       o_PcWrite,
  output logic       o_PcSource,
  output logic       o_Retire,
  output logic       o_Halted,
  output logic [1:0] o_HaltCause
`ifdef RETIRE_COUNTER_EN
  ,
  output logic [63:0] o_RetireCount
`endif
);

  // Counter only has to reach TIMEOUT_CYCLES-1; a zero parameter disables the timeout.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_HALT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          jump_q, jump_d;
  logic [1:0]    cause_q, cause_d;
  logic          timeout;

  // State, bus wait counter, jump flag and halt cause registers.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q    <= S_RESET;
      wait_cnt_q <= '0;
      jump_q     <= 1'b0;
      cause_q    <= CAUSE_NONE;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      jump_q     <= jump_d;
      cause_q    <= cause_d;
    end
  end

  // Next-state and strobe decode; a ready on the last allowed cycle beats the timeout.
  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = '0;
    jump_d         = jump_q;
    cause_d        = cause_q;
    o_BusReq       = 1'b0;
    o_BusWrite     = 1'b0;
    o_BusAddrSel   = 1'b0;
    o_IrWrite      = 1'b0;
    o_OperandLatch = 1'b0;
    o_AluLatch     = 1'b0;
    o_MemDataLatch = 1'b0;
    o_RegFileWrite = 1'b0;
    o_PcWrite      = 1'b0;
    o_PcSource     = 1'b0;
    o_Retire       = 1'b0;
    o_Halted       = 1'b0;
    o_HaltCause    = cause_q;
    timeout        = TMO_EN && (wait_cnt_q == CNT_LAST) && !i_BusReady;

    case (state_q)
      S_RESET: state_d = S_FETCH;

      S_FETCH: begin
        o_BusReq = 1'b1;
        if (i_BusReady) begin
          o_IrWrite = 1'b1;
          state_d   = S_DECODE;
        end else if (timeout) begin
          state_d = S_HALT;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      S_DECODE: begin
        o_OperandLatch = 1'b1;
        if (i_IllegalInstruction) begin
          state_d = S_HALT;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = S_EXECUTE;
        end
      end

      S_EXECUTE: begin
        o_AluLatch = 1'b1;
        if (i_MemRead || i_MemWrite) begin
          state_d = S_MEMORY;
        end else if (i_Branch) begin
          o_PcWrite  = 1'b1;
          o_PcSource = i_BranchTaken;
          o_Retire   = 1'b1;
          state_d    = S_FETCH;
        end else if (i_Jump) begin
          // PC stays put until writeback so the link value is the old PC.
          jump_d  = 1'b1;
          state_d = S_WRITEBACK;
        end else begin
          state_d = S_WRITEBACK;
        end
      end

      S_MEMORY: begin
        o_BusReq     = 1'b1;
        o_BusAddrSel = 1'b1;
        o_BusWrite   = i_MemWrite;
        if (i_BusReady) begin
          if (i_MemWrite) begin
            o_PcWrite = 1'b1;
            o_Retire  = 1'b1;
            state_d   = S_FETCH;
          end else begin
            o_MemDataLatch = 1'b1;
            state_d        = S_WRITEBACK;
          end
        end else if (timeout) begin
          state_d = S_HALT;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      S_WRITEBACK: begin
        o_RegFileWrite = i_RegWrite;
        o_PcWrite      = 1'b1;
        o_PcSource     = jump_q;
        o_Retire       = 1'b1;
        jump_d         = 1'b0;
        state_d        = S_FETCH;
      end

      S_HALT: o_Halted = 1'b1;

      default: state_d = S_HALT;
    endcase
  end

`ifdef RETIRE_COUNTER_EN
  logic [63:0] retire_cnt_q;

  // Count retired instructions; wraps naturally and cannot move in HALT.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      retire_cnt_q <= '0;
    end else if (o_Retire) begin
      retire_cnt_q <= retire_cnt_q + 64'd1;
    end
  end

  assign o_RetireCount = retire_cnt_q;
`endif

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
Control FSM for the multi-cycle RV32I core. Steps each instruction through fetch, decode, execute, memory and writeback around the shared ALU/regfile/PC datapath, consuming the decoder's control outputs. Arbitrates the single memory bus between instruction fetch and load/store. Halts on illegal instruction or bus timeout.

Parameters:
TIMEOUT_CYCLES, 256, max cycles a bus request may wait for i_BusReady; 0 disables the timeout.

Ports:
i_Clock  in  1  core clock
i_Reset_n  in  1  asynchronous, active-low reset
i_Branch  in  1  decoder: conditional branch
i_Jump  in  1  decoder: JAL/JALR
i_RegWrite  in  1  decoder: instruction writes rd
i_MemRead  in  1  decoder: load
i_MemWrite  in  1  decoder: store
i_IllegalInstruction  in  1  decoder: illegal/unimplemented
i_BranchTaken  in  1  ALU compare result, valid in EXECUTE
i_BusReady  in  1  bus accepts/completes current request this cycle
o_BusReq  out  1  bus request, held until i_BusReady
o_BusWrite  out  1  1 = store, 0 = read
o_BusAddrSel  out  1  0 = PC (fetch), 1 = ALU result (load/store)
o_IrWrite  out  1  latch fetched instruction word
o_OperandLatch  out  1  latch rs1/rs2 and immediate
o_AluLatch  out  1  latch ALU result
o_MemDataLatch  out  1  latch load data
o_RegFileWrite  out  1  regfile write strobe
o_PcWrite  out  1  PC update strobe
o_PcSource  out  1  0 = PC+4, 1 = branch/jump target
o_Retire  out  1  one-cycle pulse per completed instruction
o_Halted  out  1  sticky halt
o_HaltCause  out  2  00 none, 01 illegal, 10 bus timeout

Behaviour:
- States: RESET, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT. Outputs decode combinationally from state and inputs.
- Reset asserted: state RESET, wait counter 0, jump flag 0, o_HaltCause 00. All outputs 0 while in RESET. Any in-flight o_BusReq drops immediately.
- RESET: always goes to FETCH on the next edge.
- FETCH: o_BusReq=1, o_BusWrite=0, o_BusAddrSel=0.
  - On i_BusReady=1: o_IrWrite=1 that cycle, next state DECODE.
- DECODE (1 cycle): o_OperandLatch=1.
  - If i_IllegalInstruction: next state HALT, cause 01.
  - Else next state EXECUTE.
  - Decoder inputs are stable from DECODE until the next FETCH.
- EXECUTE (1 cycle): o_AluLatch=1. Next state by priority:
  - Load or store: MEMORY.
  - Branch: o_PcWrite=1, o_PcSource=i_BranchTaken, o_Retire=1, next state FETCH.
  - Jump: set jump flag, next state WRITEBACK; PC not written here, so the link value uses the old PC.
  - Otherwise: WRITEBACK.
- MEMORY: o_BusReq=1, o_BusAddrSel=1, o_BusWrite=i_MemWrite. On i_BusReady=1:
  - Load: o_MemDataLatch=1, next state WRITEBACK.
  - Store: o_PcWrite=1, o_PcSource=0, o_Retire=1, next state FETCH.
- WRITEBACK (1 cycle): o_RegFileWrite=i_RegWrite, o_PcWrite=1, o_PcSource=jump flag, o_Retire=1. Clear jump flag; next state FETCH.
- Bus wait counter:
  - Clears on entry to FETCH/MEMORY and on i_BusReady.
  - Increments each FETCH/MEMORY cycle with i_BusReady=0.
  - When the counter equals TIMEOUT_CYCLES-1 with i_BusReady=0: next state HALT, cause 10, and the request drops.
  - If i_BusReady=1 arrives on that same cycle, ready wins and there is no timeout.
- HALT: o_Halted=1, o_HaltCause held, all strobes 0, bus idle. Only reset exits HALT.
- i_BusReady is ignored when o_BusReq=0.
- Latencies with zero-wait bus:
  - ALU op: 4 cycles.
  - Branch: 3 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Jump: 4 cycles.

Optional Feature:
RETIRE_COUNTER_EN: when defined, adds output o_RetireCount (64 bits).
- Resets to 0 and increments on every o_Retire pulse.
- Wraps from all-ones to 0.
- Holds its value in HALT.
When undefined, the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, zero-wait bus, ADDI (i_RegWrite=1): state sequence FETCH, DECODE, EXECUTE, WRITEBACK → o_RegFileWrite=1, o_PcWrite=1, o_PcSource=0 in cycle 4, a single o_Retire pulse.
- Load with i_BusReady delayed 3 cycles in MEMORY: o_BusReq=1, o_BusAddrSel=1, o_BusWrite=0 held 4 cycles → o_MemDataLatch then o_RegFileWrite, total 8 cycles.
- Branch with i_BranchTaken=1 then 0: o_PcWrite=1 in EXECUTE with o_PcSource=1 then 0 → never enters WRITEBACK, o_RegFileWrite stays 0.
- JAL: no o_PcWrite in EXECUTE → WRITEBACK has o_PcWrite=1, o_PcSource=1, o_RegFileWrite=1; next instruction's WRITEBACK has o_PcSource=0.
- TIMEOUT_CYCLES=4, i_BusReady held 0 in FETCH → HALT after 4 request cycles, o_HaltCause=10. Repeat with i_BusReady=1 on the 4th cycle → proceeds to DECODE, no halt.
- i_IllegalInstruction=1 in DECODE → HALT, o_HaltCause=01, all strobes 0. Assert i_Reset_n=0 mid-MEMORY wait → o_BusReq=0 immediately; after release the first fetch starts.
